// File: rtl/alu_ab_datapath.sv
// rtl/alu_ab_datapath.sv - SAP-style A/B accumulator datapath with a registered ALU
// Optional rotate-through-carry of A and B is enabled by defining AB_ROTATE_EN.
module alu_ab_datapath #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] ram_to_a,
  input  logic [W-1:0] ram_to_b,
  input  logic [W-1:0] tmp_to_b,
  input  logic [W-1:0] tmp_to_alu,
  input  logic         carry_in,
  input  logic         la_ram,
  input  logic         la_b,
  input  logic         la_alu,
  input  logic         lb_tmp,
  input  logic         lb_alu,
  input  logic         lb_pop,
  input  logic         lb_carry,
  input  logic         ea_tmp,
  input  logic         ea_ram,
  input  logic         ea_out,
  input  logic         eb_a,
  input  logic         eb_push,
  input  logic         eu,
  input  logic         ercl,
  input  logic         ea_carry,
  output logic [W-1:0] a_to_alu,
  output logic [W-1:0] b_to_alu,
  output logic [W-1:0] a_to_tmp,
  output logic [W-1:0] a_to_ram,
  output logic [W-1:0] a_to_out,
  output logic [W-1:0] b_to_a,
  output logic [W-1:0] b_to_ram,
  output logic         zero,
  output logic         carry,
  output logic         carry_from_a,
  output logic         carry_from_b
);

  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] alu_res;
  logic [W:0]   alu_sum;
  logic         alu_valid;

  assign a_to_alu = a_reg;
  assign b_to_alu = b_reg;
  assign a_to_tmp = ea_tmp  ? a_reg : '0;
  assign a_to_ram = ea_ram  ? a_reg : '0;
  assign a_to_out = ea_out  ? a_reg : '0;
  assign b_to_a   = eb_a    ? b_reg : '0;
  assign b_to_ram = eb_push ? b_reg : '0;

  // Logic ops leave bit W clear, so carry falls out of the same sum vector.
  always_comb begin
    alu_sum   = '0;
    alu_valid = 1'b1;
    case (opcode)
      4'b0001: alu_sum = {1'b0, a_reg} + {1'b0, b_reg};
      4'b0010: alu_sum = {1'b0, a_reg} - {1'b0, b_reg};
      4'b0100: alu_sum = {1'b0, a_reg & b_reg};
      4'b0101: alu_sum = {1'b0, a_reg | b_reg};
      4'b0110: alu_sum = {1'b0, a_reg ^ b_reg};
      4'b1000: alu_sum = {1'b0, b_reg} + {1'b0, tmp_to_alu};
      4'b1001: alu_sum = {1'b0, b_reg | tmp_to_alu};
      4'b1010: alu_sum = {1'b0, b_reg & tmp_to_alu};
      default: alu_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_res <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else if (eu && alu_valid) begin
      alu_res <= alu_sum[W-1:0];
      zero    <= (alu_sum[W-1:0] == '0);
      carry   <= alu_sum[W];
    end
  end

  // Both registers sample each other's pre-edge value, so la_b + lb_tmp swaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
    end else if (la_ram) begin
      a_reg <= ram_to_a;
    end else if (la_b) begin
      a_reg <= b_reg;
    end else if (la_alu) begin
      a_reg <= alu_res;
`ifdef AB_ROTATE_EN
    end else if (ea_carry) begin
      a_reg <= {a_reg[W-2:0], carry_in};
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_reg <= '0;
    end else if (lb_tmp) begin
      b_reg <= tmp_to_b;
    end else if (lb_pop) begin
      b_reg <= ram_to_b;
    end else if (lb_alu) begin
      b_reg <= alu_res;
    end else if (lb_carry) begin
      b_reg <= {{(W-1){1'b0}}, carry_in};
`ifdef AB_ROTATE_EN
    end else if (ercl) begin
      b_reg <= {b_reg[W-2:0], carry_in};
`endif
    end
  end

`ifdef AB_ROTATE_EN
  // The shifted-out bit is only captured when the rotate actually wins priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_from_a <= 1'b0;
      carry_from_b <= 1'b0;
    end else begin
      if (!la_ram && !la_b && !la_alu && ea_carry)
        carry_from_a <= a_reg[W-1];
      if (!lb_tmp && !lb_pop && !lb_alu && !lb_carry && ercl)
        carry_from_b <= b_reg[W-1];
    end
  end
`else
  logic unused_rotate;
  assign unused_rotate = ercl ^ ea_carry;
  assign carry_from_a  = 1'b0;
  assign carry_from_b  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ab_datapath.sv
// tb/tb_alu_ab_datapath.sv - randomized self-checking bench for alu_ab_datapath
module tb_alu_ab_datapath;

`ifdef AB_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [3:0] opcode, ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu;
  logic carry_in, la_ram, la_b, la_alu, lb_tmp, lb_alu, lb_pop, lb_carry;
  logic ea_tmp, ea_ram, ea_out, eb_a, eb_push, eu, ercl, ea_carry;
  logic [3:0] a_to_alu, b_to_alu, a_to_tmp, a_to_ram, a_to_out, b_to_a, b_to_ram;
  logic zero, carry, carry_from_a, carry_from_b;

  int errors = 0;
  int checks = 0;

  // Reference state kept as plain integers.
  int m_a, m_b, m_res, m_z, m_c, m_cfa, m_cfb;

  always #5 clk = ~clk;

  alu_ab_datapath #(.W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .ram_to_a(ram_to_a), .ram_to_b(ram_to_b), .tmp_to_b(tmp_to_b),
    .tmp_to_alu(tmp_to_alu), .carry_in(carry_in),
    .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
    .lb_tmp(lb_tmp), .lb_alu(lb_alu), .lb_pop(lb_pop), .lb_carry(lb_carry),
    .ea_tmp(ea_tmp), .ea_ram(ea_ram), .ea_out(ea_out), .eb_a(eb_a), .eb_push(eb_push),
    .eu(eu), .ercl(ercl), .ea_carry(ea_carry),
    .a_to_alu(a_to_alu), .b_to_alu(b_to_alu), .a_to_tmp(a_to_tmp),
    .a_to_ram(a_to_ram), .a_to_out(a_to_out), .b_to_a(b_to_a), .b_to_ram(b_to_ram),
    .zero(zero), .carry(carry), .carry_from_a(carry_from_a), .carry_from_b(carry_from_b)
  );

  task automatic idle();
    {la_ram, la_b, la_alu, lb_tmp, lb_alu, lb_pop, lb_carry} = '0;
    {ea_tmp, ea_ram, ea_out, eb_a, eb_push, eu, ercl, ea_carry} = '0;
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_res = 0; m_z = 0; m_c = 0; m_cfa = 0; m_cfb = 0;
  endtask

  // Next state from the behavioural rules, using pre-edge model values.
  task automatic model_edge();
    int na, nb, s, r, cy;
    bit ok;
    na = m_a; nb = m_b;
    if (la_ram)                 na = int'(ram_to_a);
    else if (la_b)              na = m_b;
    else if (la_alu)            na = m_res;
    else if (ROT && ea_carry) begin
      na = (m_a * 2 + int'(carry_in)) % 16; m_cfa = (m_a >= 8) ? 1 : 0;
    end
    if (lb_tmp)                 nb = int'(tmp_to_b);
    else if (lb_pop)            nb = int'(ram_to_b);
    else if (lb_alu)            nb = m_res;
    else if (lb_carry)          nb = int'(carry_in);
    else if (ROT && ercl) begin
      nb = (m_b * 2 + int'(carry_in)) % 16; m_cfb = (m_b >= 8) ? 1 : 0;
    end
    if (eu) begin
      ok = 1'b1; s = 0;
      case (int'(opcode))
        1:  s = m_a + m_b;
        2:  s = m_a - m_b;
        4:  s = m_a & m_b;
        5:  s = m_a | m_b;
        6:  s = m_a ^ m_b;
        8:  s = m_b + int'(tmp_to_alu);
        9:  s = m_b | int'(tmp_to_alu);
        10: s = m_b & int'(tmp_to_alu);
        default: ok = 1'b0;
      endcase
      if (ok) begin
        cy = (s > 15 || s < 0) ? 1 : 0;
        r = (s + 16) % 16;
        m_res = r; m_c = cy; m_z = (r == 0) ? 1 : 0;
      end
    end
    m_a = na; m_b = nb;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    opcode = 0; ram_to_a = 0; ram_to_b = 0; tmp_to_b = 0; tmp_to_alu = 0; carry_in = 0;
    ea_tmp = 1; ea_ram = 1; ea_out = 1; eb_a = 1; eb_push = 1;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({a_to_alu, b_to_alu, a_to_tmp, a_to_ram, a_to_out, b_to_a, b_to_ram} !== 28'h0) begin
      errors++;
      $display("FAIL reset_buses: got a=%h b=%h tmp=%h ram=%h out=%h ba=%h bram=%h, expected all 0",
               a_to_alu, b_to_alu, a_to_tmp, a_to_ram, a_to_out, b_to_a, b_to_ram);
    end
    checks++;
    if ({zero, carry, carry_from_a, carry_from_b} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got z=%b c=%b cfa=%b cfb=%b, expected 0000",
               zero, carry, carry_from_a, carry_from_b);
    end
    reset = 1'b0; idle();
  endtask

  task automatic test_load();
    ram_to_a = 4'd3; la_ram = 1; ea_tmp = 1;
    tick();
    checks++;
    if (a_to_alu !== 4'd3) begin
      errors++; $display("FAIL load_a: got %h expected 3", a_to_alu);
    end
    checks++;
    if (a_to_tmp !== 4'd3) begin
      errors++; $display("FAIL a_to_tmp: got %h expected 3", a_to_tmp);
    end
    checks++;
    if (b_to_a !== 4'd0) begin
      errors++; $display("FAIL b_to_a_gated: got %h expected 0", b_to_a);
    end
    idle();
  endtask

  task automatic test_swap();
    la_b = 1; lb_tmp = 1; tmp_to_b = a_to_alu;
    tick();
    checks++;
    if (a_to_alu !== 4'd0 || b_to_alu !== 4'd3) begin
      errors++; $display("FAIL swap: got A=%h B=%h expected A=0 B=3", a_to_alu, b_to_alu);
    end
    idle();
  endtask

  task automatic test_alu_tmp();
    tmp_to_alu = 4'd5; opcode = 4'b1001; eu = 1;
    tick();
    idle(); lb_alu = 1;
    tick();
    checks++;
    if (b_to_alu !== 4'd7 || zero !== 1'b0 || carry !== 1'b0) begin
      errors++; $display("FAIL or_tmp: got B=%h z=%b c=%b expected B=7 z=0 c=0", b_to_alu, zero, carry);
    end
    idle();
  endtask

  task automatic test_add_carry();
    ram_to_a = 4'hF; la_ram = 1; tmp_to_b = 4'h1; lb_tmp = 1;
    tick();
    idle(); opcode = 4'b0001; eu = 1;
    tick();
    idle(); la_alu = 1;
    tick();
    checks++;
    if (a_to_alu !== 4'h0 || zero !== 1'b1 || carry !== 1'b1) begin
      errors++; $display("FAIL add_carry: got A=%h z=%b c=%b expected A=0 z=1 c=1", a_to_alu, zero, carry);
    end
    idle();
  endtask

  task automatic test_sub_and_invalid();
    ram_to_a = 4'h2; la_ram = 1; tmp_to_b = 4'h5; lb_tmp = 1;
    tick();
    idle(); opcode = 4'b0010; eu = 1;
    tick();
    idle(); opcode = 4'b0011; eu = 1;
    tick();
    idle(); la_alu = 1;
    tick();
    checks++;
    if (a_to_alu !== 4'hD || zero !== 1'b0 || carry !== 1'b1) begin
      errors++; $display("FAIL sub_borrow_hold: got A=%h z=%b c=%b expected A=d z=0 c=1", a_to_alu, zero, carry);
    end
    idle();
  endtask

  task automatic test_rotate();
    tmp_to_b = 4'b1000; lb_tmp = 1;
    tick();
    idle(); carry_in = 1; ercl = 1;
    tick();
    checks++;
    if (b_to_alu !== (ROT ? 4'b0001 : 4'b1000) || carry_from_b !== ROT) begin
      errors++; $display("FAIL rotate_b: got B=%b cfb=%b expected B=%b cfb=%b",
                         b_to_alu, carry_from_b, ROT ? 4'b0001 : 4'b1000, ROT);
    end
    idle(); carry_in = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      opcode = 4'($urandom_range(0, 15));
      ram_to_a = 4'($urandom); ram_to_b = 4'($urandom);
      tmp_to_b = 4'($urandom); tmp_to_alu = 4'($urandom);
      carry_in = 1'($urandom);
      la_ram = ($urandom_range(0, 4) == 0); la_b = ($urandom_range(0, 4) == 0);
      la_alu = ($urandom_range(0, 3) == 0); lb_tmp = ($urandom_range(0, 4) == 0);
      lb_alu = ($urandom_range(0, 3) == 0); lb_pop = ($urandom_range(0, 4) == 0);
      lb_carry = ($urandom_range(0, 4) == 0); eu = ($urandom_range(0, 1) == 0);
      ercl = ($urandom_range(0, 2) == 0); ea_carry = ($urandom_range(0, 2) == 0);
      ea_tmp = 1'($urandom); ea_ram = 1'($urandom); ea_out = 1'($urandom);
      eb_a = 1'($urandom); eb_push = 1'($urandom);
      tick();
      checks++;
      if (int'(a_to_alu) != m_a || int'(b_to_alu) != m_b) begin
        errors++; $display("FAIL rand_ab[%0d]: got A=%h B=%h expected A=%h B=%h", i, a_to_alu, b_to_alu, m_a, m_b);
      end
      checks++;
      if (int'(zero) != m_z || int'(carry) != m_c || int'(carry_from_a) != m_cfa || int'(carry_from_b) != m_cfb) begin
        errors++; $display("FAIL rand_flags[%0d]: got z=%b c=%b cfa=%b cfb=%b expected z=%0d c=%0d cfa=%0d cfb=%0d",
                           i, zero, carry, carry_from_a, carry_from_b, m_z, m_c, m_cfa, m_cfb);
      end
      checks++;
      if (int'(a_to_tmp) != (ea_tmp ? m_a : 0) || int'(a_to_ram) != (ea_ram ? m_a : 0) ||
          int'(a_to_out) != (ea_out ? m_a : 0) || int'(b_to_a) != (eb_a ? m_b : 0) ||
          int'(b_to_ram) != (eb_push ? m_b : 0)) begin
        errors++; $display("FAIL rand_buses[%0d]: got tmp=%h ram=%h out=%h ba=%h bram=%h for A=%h B=%h",
                           i, a_to_tmp, a_to_ram, a_to_out, b_to_a, b_to_ram, m_a, m_b);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    ram_to_a = 4'h5; la_ram = 1; tmp_to_b = 4'h9; lb_tmp = 1; tmp_to_alu = 4'h6;
    opcode = 4'b1000; eu = 1;
    tick();
    checks++;
    if (a_to_alu !== 4'h5) begin
      errors++; $display("FAIL pre_reset_a: got %h expected 5", a_to_alu);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (a_to_alu !== 4'h0 || b_to_alu !== 4'h0 || zero !== 1'b0 || carry !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got A=%h B=%h z=%b c=%b expected all 0", a_to_alu, b_to_alu, zero, carry);
    end
    @(posedge clk); #1;
    reset = 1'b0; idle(); model_clear();
    tick();
    checks++;
    if (a_to_alu !== 4'h0 || b_to_alu !== 4'h0) begin
      errors++; $display("FAIL after_reset: got A=%h B=%h expected 0 0", a_to_alu, b_to_alu);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_swap();
    test_alu_tmp();
    test_add_carry();
    test_sub_and_invalid();
    test_rotate();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
